// File: rtl/fc_pingpong_sched.sv
// rtl/fc_pingpong_sched.sv - ping-pong x-bank scheduler for a fully connected layer
// Loader fills one x bank while the compute FSM walks rows over the other.
module fc_pingpong_sched #(
  parameter int M = 8,
  parameter int N = 4,
  parameter int T = 16,
  parameter int P = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        input_valid,
  output logic                        input_ready,
  input  logic                        output_ready,
  output logic                        output_valid,
  output logic [$clog2(N):0]          addr_x,
  output logic                        wr_en_x,
  output logic [$clog2(M*N/P)-1:0]    addr_w,
  output logic                        clear_acc,
  output logic                        en_acc,
  output logic [P-1:0]                f_sel
);

  localparam int KW  = $clog2(N);
  localparam int RW  = $clog2(M);
  localparam int WAW = $clog2(M*N/P);

  typedef enum logic [1:0] {C_IDLE, C_MAC, C_DRAIN, C_OUT} state_t;

  state_t          state, state_n;
  logic            wb, cb, cb_n;
  logic [1:0]      full, full_n;
  logic [KW-1:0]   wp, k, k_n;
  logic [RW-1:0]   r, r_n;
  logic            accept, issue, handshake;

  assign input_ready = reset && !full[wb];
  assign accept      = input_valid && input_ready;
  assign wr_en_x     = accept;

  // The loader write owns the shared x address port whenever it fires.
  assign addr_x = accept ? {wb, wp} : {cb, k};

  // k saturates at N-1 after the last issue, so addr_w holds steady through drain and output.
  assign addr_w = WAW'(r) * WAW'(N) + WAW'(k);

  always_comb begin
    state_n      = state;
    k_n          = k;
    r_n          = r;
    cb_n         = cb;
    full_n       = full;
    issue        = 1'b0;
    handshake    = 1'b0;
    clear_acc    = 1'b0;
    output_valid = 1'b0;
    f_sel        = '0;
    case (state)
      C_IDLE: begin
        if (full[cb]) begin
          state_n = C_MAC;
          k_n     = '0;
          r_n     = '0;
        end
      end
      C_MAC: begin
        if (!accept) begin
          issue     = 1'b1;
          clear_acc = (k == '0);
          if (k == KW'(N-1)) state_n = C_DRAIN;
          else               k_n     = k + 1'b1;
        end
      end
      C_DRAIN: state_n = C_OUT;
      C_OUT: begin
        output_valid = 1'b1;
        f_sel        = P'(1);
        if (output_ready) begin
          handshake = 1'b1;
          k_n       = '0;
          if (r == RW'(M-1)) begin
            r_n     = '0;
            cb_n    = ~cb;
            state_n = full[~cb] ? C_MAC : C_IDLE;
          end else begin
            r_n     = r + 1'b1;
            state_n = C_MAC;
          end
        end
      end
      default: state_n = C_IDLE;
    endcase
    // wb and cb never name the same bank when both of these fire.
    if (accept && wp == KW'(N-1)) full_n[wb] = 1'b1;
    if (handshake && r == RW'(M-1)) full_n[cb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= C_IDLE;
      wb     <= 1'b0;
      cb     <= 1'b0;
      wp     <= '0;
      k      <= '0;
      r      <= '0;
      full   <= '0;
      en_acc <= 1'b0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      r      <= r_n;
      cb     <= cb_n;
      full   <= full_n;
      en_acc <= issue;
      if (accept) begin
        if (wp == KW'(N-1)) begin
          wp <= '0;
          wb <= ~wb;
        end else begin
          wp <= wp + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/fc_pingpong_sched.md
FC_PINGPONG_SCHED -- requirements
Module: fc_pingpong_sched

Interface
REQ-001 Parameters, one per line (name, default, meaning): M, 8, output rows; N, 4, input vector length; T, 16, data width; P, 1, parallel lanes (only P=1 supported).
REQ-002 Ports, one per line (name, direction, width, meaning):
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
input_valid  input  1  upstream element valid
input_ready  output  1  scheduler accepts element this cycle
output_ready  input  1  downstream accepts y element
output_valid  output  1  y element valid on datapath output
addr_x  output  $clog2(N)+1  vector memory address; MSB = bank, LSBs = element index
wr_en_x  output  1  vector memory write strobe
addr_w  output  $clog2(M*N/P)  weight ROM address
clear_acc  output  1  zero accumulator at this edge
en_acc  output  1  accumulate product of the previous cycle's reads
f_sel  output  P  output lane select

Function
REQ-003 Two x banks (0/1), each with a full flag; the loader fills bank wb while compute consumes bank cb.
REQ-004 input_ready SHALL be 1 iff reset is high and full[wb]==0.
REQ-005 Accept = input_valid && input_ready; on accept: wr_en_x=1, addr_x={wb,wp}, wp increments; accept with wp==N-1 sets full[wb], wp=0, wb toggles.
REQ-006 addr_x is shared: on an accept cycle the write owns addr_x, and compute SHALL NOT issue a read (stall); writes always win.
REQ-007 Compute FSM states: C_IDLE, C_MAC, C_DRAIN, C_OUT.
REQ-008 C_IDLE -> C_MAC when full[cb]==1; row r=0, k=0.
REQ-009 C_MAC, no stall: issue read addr_x={cb,k}, addr_w=r*N+k, k++; clear_acc=1 on the k==0 issue cycle only; after the k==N-1 issue -> C_DRAIN.
REQ-010 A stall freezes k, r and state; clear_acc=0 in the stalled cycle.
REQ-011 en_acc SHALL equal a register of "read issued" from the previous cycle; it is 1 in C_DRAIN and never 1 in C_IDLE or C_OUT.
REQ-012 C_DRAIN -> C_OUT unconditionally after one cycle.
REQ-013 C_OUT: output_valid=1 and f_sel=1 (lane 0); hold until output_ready is sampled high; addresses and accumulator remain stable while waiting.
REQ-014 On C_OUT handshake with r<M-1: r++, k=0 -> C_MAC. With r==M-1: clear full[cb], toggle cb, go to C_MAC if the new full[cb]==1, else C_IDLE.
REQ-015 Same-edge set of full[wb] by the loader and clear of full[cb] by compute SHALL both take effect; banks differ by construction.
REQ-016 Row latency without stalls SHALL be N+2 cycles with output_ready held high; a vector takes M*(N+2) = 48 cycles.
REQ-017 First output_valid SHALL rise N+2 = 6 cycles after the edge that accepts the last element of a vector, when compute is idle.
REQ-018 Weight ROM and vector memory have 1-cycle read latency; addr_w spans 0..M*N-1 with no wrap beyond M*N-1.
REQ-019 With both banks full, input_ready SHALL stay 0 until compute releases a bank.

Reset
REQ-020 reset==0 at a rising edge: state C_IDLE; wb=cb=0; wp=k=r=0; full flags 0; next-cycle outputs output_valid=0, en_acc=0, clear_acc=0, wr_en_x=0, addr_x=0, addr_w=0, f_sel=0.
REQ-021 input_ready SHALL be 0 whenever reset is low.
REQ-022 Reset mid-vector or mid-output SHALL discard all partial loads and results; nothing is emitted after reset is released.

Verification
REQ-023 Load x=1,2,3,4 with output_ready=1: first output_valid 6 cycles after the 4th accept; 8 outputs at 6-cycle spacing; addr_w sequence 0..31.
REQ-024 Stream two vectors back-to-back: the second loads into bank 1 during compute with writes stalling reads (en_acc gap after each accept); results match relu(W*x) for both vectors.
REQ-025 Hold output_ready=0 for 10 cycles at row 3: output_valid stays 1 and addr_w is stable; processing resumes on release.
REQ-026 Load three vectors with output_ready=0: input_ready=0 after the 8th accept until the row-7 handshake of vector 0.
REQ-027 Pull reset low during C_MAC of row 2: all outputs zero next cycle; input_ready=0 during reset; a fresh vector then produces a correct full result.
